// File: rtl/mdu_ctrl_pkg.sv
// rtl/mdu_ctrl_pkg.sv - MDU operation codes, FSM state codes and decode helper
//
// Purpose : shared definitions for the multiply/divide unit.
//           MDOP_* operation codes, MDU_IDLE/MDU_BUSY state codes and a
//           decode helper naming the ops that occupy the unit for several cycles.
// Ports   : none (package).
// Config  : MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU to the multi-cycle set.
package mdu_ctrl_pkg;

   localparam int MDOP_SIZE = 4;

   typedef enum logic [MDOP_SIZE-1:0] {
      MDOP_NONE  = 4'd0,
      MDOP_MULT  = 4'd1,
      MDOP_MULTU = 4'd2,
      MDOP_DIV   = 4'd3,
      MDOP_DIVU  = 4'd4,
      MDOP_MFHI  = 4'd5,
      MDOP_MFLO  = 4'd6,
      MDOP_MTHI  = 4'd7,
      MDOP_MTLO  = 4'd8,
      MDOP_MADD  = 4'd9,
      MDOP_MADDU = 4'd10,
      MDOP_MSUB  = 4'd11,
      MDOP_MSUBU = 4'd12
   } mdop_e;

   typedef enum logic {
      MDU_IDLE = 1'b0,
      MDU_BUSY = 1'b1
   } mdu_state_e;

   // Ops that start a multi-cycle busy window (and therefore stall D-stage MDU ops).
   function automatic logic mdop_is_long(input logic [MDOP_SIZE-1:0] op);
      case (op)
         MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU: return 1'b1;
`ifdef MDU_MADD_EN
         MDOP_MADD, MDOP_MADDU, MDOP_MSUB, MDOP_MSUBU: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational 64-bit product and 32-bit quotient/remainder
//
// Purpose : pure datapath for the MDU; the sequencing lives in mdu_ctrl.
// Ports   : op[3:0]        operation code (selects signedness)
//           operand1[31:0] rs value
//           operand2[31:0] rt value
//           prod[63:0]     full product (signed for MULT/MADD/MSUB, else unsigned)
//           quot[31:0]     quotient, truncated toward zero
//           rem[31:0]      remainder, sign follows dividend
//           keep           divide by zero: HI/LO must not be written
module mdu_calc
   import mdu_ctrl_pkg::*;
(
   input  logic [MDOP_SIZE-1:0] op,
   input  logic [31:0]          operand1,
   input  logic [31:0]          operand2,
   output logic [63:0]          prod,
   output logic [31:0]          quot,
   output logic [31:0]          rem,
   output logic                 keep
);

   logic        mul_signed;
   logic [63:0] ext1;
   logic [63:0] ext2;

   logic        div_signed;
   logic        neg1;
   logic        neg2;
   logic [31:0] mag1;
   logic [31:0] mag2;
   logic [31:0] uquot;
   logic [31:0] urem;
   logic        is_div;

   assign mul_signed = (op == MDOP_MULT) || (op == MDOP_MADD) || (op == MDOP_MSUB);

   // Low 64 bits of the product of the extended operands equal the true
   // signed (or unsigned) 64-bit product, so one multiplier serves both.
   assign ext1 = mul_signed ? {{32{operand1[31]}}, operand1} : {32'd0, operand1};
   assign ext2 = mul_signed ? {{32{operand2[31]}}, operand2} : {32'd0, operand2};
   assign prod = ext1 * ext2;

   // Signed divide runs on magnitudes and re-applies the signs; this also
   // gives 0x80000000 / -1 = 0x80000000 rem 0 without special-casing.
   assign div_signed = (op == MDOP_DIV);
   assign neg1  = div_signed & operand1[31];
   assign neg2  = div_signed & operand2[31];
   assign mag1  = neg1 ? (-operand1) : operand1;
   assign mag2  = neg2 ? (-operand2) : operand2;
   assign uquot = (mag2 == '0) ? '0 : (mag1 / mag2);
   assign urem  = (mag2 == '0) ? '0 : (mag1 % mag2);
   assign quot  = (neg1 ^ neg2) ? (-uquot) : uquot;
   assign rem   = neg1 ? (-urem) : urem;

   assign is_div = (op == MDOP_DIV) || (op == MDOP_DIVU);
   assign keep   = is_div && (operand2 == '0);

endmodule

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multiply/divide unit sequencer with HI/LO and stall request
//
// Purpose : accepts one MDU op per start pulse, holds HI/LO, models
//           multi-cycle latency with a busy counter and raises stall for
//           D-stage MDU instructions while an operation is in flight.
// Ports   : clk             rising-edge clock
//           reset           asynchronous active-low reset
//           start           E-stage MDU instruction valid
//           op[3:0]         MDOP_* operation code
//           operand1[31:0]  forwarded rs value
//           operand2[31:0]  forwarded rt value
//           D_is_md         D-stage instruction is an MDU op
//           busy            operation in flight
//           stall           stall request to hazard unit
//           read_data[31:0] HI for MFHI, LO for MFLO, else 0
// Config  : MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU ({HI,LO} +/- product);
//           otherwise those codes are no-ops. DEBUG enables a start-while-busy check.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [MDOP_SIZE-1:0] op,
   input  logic [31:0]          operand1,
   input  logic [31:0]          operand2,
   input  logic                 D_is_md,
   output logic                 busy,
   output logic                 stall,
   output logic [31:0]          read_data
);

   localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   mdu_state_e       state;
   logic [CNT_W-1:0] counter;
   logic [31:0]      hi;
   logic [31:0]      lo;
   logic [31:0]      pend_hi;
   logic [31:0]      pend_lo;
   logic             pend_keep;

   logic [63:0]      prod;
   logic [31:0]      quot;
   logic [31:0]      rem;
   logic             keep;

   mdu_calc u_calc (
      .op       (op),
      .operand1 (operand1),
      .operand2 (operand2),
      .prod     (prod),
      .quot     (quot),
      .rem      (rem),
      .keep     (keep)
   );

   // The result is computed at start and parked in pend_*; HI/LO only change
   // on the final busy edge so an aborted op never touches them.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= MDU_IDLE;
         busy      <= 1'b0;
         counter   <= '0;
         hi        <= '0;
         lo        <= '0;
         pend_hi   <= '0;
         pend_lo   <= '0;
         pend_keep <= 1'b0;
      end else begin
         case (state)
            MDU_IDLE: begin
               if (start) begin
                  case (op)
                     MDOP_MULT, MDOP_MULTU: begin
                        {pend_hi, pend_lo} <= prod;
                        pend_keep          <= 1'b0;
                        counter            <= MULT_LOAD;
                        state              <= MDU_BUSY;
                        busy               <= 1'b1;
                     end
                     MDOP_DIV, MDOP_DIVU: begin
                        pend_hi   <= rem;
                        pend_lo   <= quot;
                        pend_keep <= keep;
                        counter   <= DIV_LOAD;
                        state     <= MDU_BUSY;
                        busy      <= 1'b1;
                     end
`ifdef MDU_MADD_EN
                     // Accumulator is the HI/LO value at start; wraps modulo 2^64.
                     MDOP_MADD, MDOP_MADDU: begin
                        {pend_hi, pend_lo} <= {hi, lo} + prod;
                        pend_keep          <= 1'b0;
                        counter            <= MULT_LOAD;
                        state              <= MDU_BUSY;
                        busy               <= 1'b1;
                     end
                     MDOP_MSUB, MDOP_MSUBU: begin
                        {pend_hi, pend_lo} <= {hi, lo} - prod;
                        pend_keep          <= 1'b0;
                        counter            <= MULT_LOAD;
                        state              <= MDU_BUSY;
                        busy               <= 1'b1;
                     end
`endif
                     MDOP_MTHI: hi <= operand1;
                     MDOP_MTLO: lo <= operand1;
                     default: ;
                  endcase
               end
            end
            MDU_BUSY: begin
               // A start arriving here is illegal and dropped.
               if (counter == '0) begin
                  if (!pend_keep) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
                  state <= MDU_IDLE;
                  busy  <= 1'b0;
               end else begin
                  counter <= counter - 1'b1;
               end
            end
            default: begin
               state <= MDU_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef DEBUG
   always_ff @(posedge clk) begin
      if (reset) begin
         assert (!(start && busy));
      end
   end
`endif

   assign stall = D_is_md && (busy || (start && mdop_is_long(op)));

   always_comb begin
      read_data = '0;
      if (op == MDOP_MFHI) begin
         read_data = hi;
      end else if (op == MDOP_MFLO) begin
         read_data = lo;
      end
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - self-checking bench for mdu_ctrl with directed and random ops
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  op = 4'd0;
   logic [31:0] operand1 = '0;
   logic [31:0] operand2 = '0;
   logic        D_is_md = 1'b0;
   logic        busy;
   logic        stall;
   logic [31:0] read_data;

   int vectors = 0;
   int miscompares = 0;
   int stall_cnt = 0;

   // Reference model state: architectural HI/LO, the result that will land
   // when the in-flight op finishes, and how many busy cycles remain.
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic [31:0] m_phi = '0;
   logic [31:0] m_plo = '0;
   logic        m_we = 1'b0;
   int          m_left = 0;

   mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .operand1  (operand1),
      .operand2  (operand2),
      .D_is_md   (D_is_md),
      .busy      (busy),
      .stall     (stall),
      .read_data (read_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic is_long(input logic [3:0] o);
      logic r;
      r = (o == MDOP_MULT) || (o == MDOP_MULTU) || (o == MDOP_DIV) || (o == MDOP_DIVU);
`ifdef MDU_MADD_EN
      r = r || (o == MDOP_MADD) || (o == MDOP_MADDU) || (o == MDOP_MSUB) || (o == MDOP_MSUBU);
`endif
      return r;
   endfunction

   task automatic launch(input logic [63:0] res, input int n, input logic we);
      {m_phi, m_plo} = res;
      m_we   = we;
      m_left = n;
   endtask

   task automatic model_edge(input logic s, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && m_we) begin
            m_hi = m_phi;
            m_lo = m_plo;
         end
      end else if (s) begin
         case (o)
            MDOP_MULT:  launch(64'(sa * sb), MULT_N, 1'b1);
            MDOP_MULTU: launch(ua * ub, MULT_N, 1'b1);
            MDOP_DIV: begin
               if (b == 0) launch('0, DIV_N, 1'b0);
               else begin
                  q = sa / sb;
                  r = sa % sb;
                  launch({r[31:0], q[31:0]}, DIV_N, 1'b1);
               end
            end
            MDOP_DIVU: begin
               if (b == 0) launch('0, DIV_N, 1'b0);
               else launch({a % b, a / b}, DIV_N, 1'b1);
            end
`ifdef MDU_MADD_EN
            MDOP_MADD:  launch({m_hi, m_lo} + 64'(sa * sb), MULT_N, 1'b1);
            MDOP_MADDU: launch({m_hi, m_lo} + ua * ub, MULT_N, 1'b1);
            MDOP_MSUB:  launch({m_hi, m_lo} - 64'(sa * sb), MULT_N, 1'b1);
            MDOP_MSUBU: launch({m_hi, m_lo} - ua * ub, MULT_N, 1'b1);
`endif
            MDOP_MTHI: m_hi = a;
            MDOP_MTLO: m_lo = a;
            default: ;
         endcase
      end
   endtask

   // One clock: drive at posedge+1, check outputs at negedge, then advance the model.
   task automatic cycle(input logic s, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic dmd);
      logic        mb;
      logic [31:0] erd;
      start = s; op = o; operand1 = a; operand2 = b; D_is_md = dmd;
      mb = (m_left > 0);
      @(negedge clk);
      chk("busy", {63'd0, busy}, {63'd0, mb});
      chk("stall", {63'd0, stall}, {63'd0, dmd && (mb || (s && is_long(o)))});
      if (stall) stall_cnt++;
      if (!(mb && (o == MDOP_MFHI || o == MDOP_MFLO))) begin
         erd = (o == MDOP_MFHI) ? m_hi : (o == MDOP_MFLO) ? m_lo : 32'd0;
         chk("read_data", {32'd0, read_data}, {32'd0, erd});
      end
      @(posedge clk);
      model_edge(s, o, a, b);
      #1;
   endtask

   task automatic idle(input int n, input logic dmd);
      for (int i = 0; i < n; i++) cycle(1'b0, MDOP_NONE, 32'd0, 32'd0, dmd);
   endtask

   // Read HI/LO through read_data without advancing the clock.
   task automatic peek(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
      start = 1'b0;
      op = MDOP_MFHI;
      #1 chk({tag, "_hi"}, {32'd0, read_data}, {32'd0, ehi});
      op = MDOP_MFLO;
      #1 chk({tag, "_lo"}, {32'd0, read_data}, {32'd0, elo});
      op = MDOP_NONE;
   endtask

   logic [3:0]  ops [13];
   logic [31:0] specials [6];

   initial begin
      ops = '{MDOP_NONE, MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU, MDOP_MFHI, MDOP_MFLO,
              MDOP_MTHI, MDOP_MTLO, MDOP_MADD, MDOP_MADDU, MDOP_MSUB, MDOP_MSUBU};
      specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};

      // Reset state
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", {63'd0, busy}, 64'd0);
      peek("reset", 32'd0, 32'd0);
      reset = 1'b1;

      // 1: signed mult, 5 busy cycles
      cycle(1'b1, MDOP_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0);
      idle(MULT_N, 1'b0);
      chk("t1_busy_done", {63'd0, busy}, 64'd0);
      peek("t1", 32'hFFFF_FFFF, 32'hFFFF_FFFE);

      // 2: divu with mflo waiting in D
      stall_cnt = 0;
      cycle(1'b1, MDOP_DIVU, 32'd7, 32'd2, 1'b1);
      stall_cnt = 0;
      idle(DIV_N, 1'b1);
      chk("t2_stall_cycles", 64'(stall_cnt), 64'(DIV_N));
      cycle(1'b1, MDOP_MFLO, 32'd0, 32'd0, 1'b1);
      peek("t2", 32'd1, 32'd3);

      // 3: signed divide boundaries
      cycle(1'b1, MDOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      idle(DIV_N, 1'b0);
      peek("t3a", 32'd0, 32'h8000_0000);
      cycle(1'b1, MDOP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
      idle(DIV_N, 1'b0);
      peek("t3b", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

      // mult -1*-1 signed and unsigned
      cycle(1'b1, MDOP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      idle(MULT_N, 1'b0);
      peek("mul_s", 32'd0, 32'd1);
      cycle(1'b1, MDOP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      idle(MULT_N, 1'b0);
      peek("mul_u", 32'hFFFF_FFFE, 32'd1);

      // 4: divide by zero keeps HI/LO; mthi accepted the cycle busy drops
      cycle(1'b1, MDOP_MTHI, 32'h1234, 32'd0, 1'b0);
      cycle(1'b1, MDOP_DIV, 32'd99, 32'd0, 1'b0);
      idle(DIV_N, 1'b0);
      peek("t4", 32'h1234, 32'd1);
      cycle(1'b1, MDOP_MULTU, 32'd3, 32'd5, 1'b0);
      idle(MULT_N, 1'b0);
      cycle(1'b1, MDOP_MTHI, 32'hABCD, 32'd0, 1'b0);
      peek("mthi_edge", 32'hABCD, 32'd15);

      // 5: async reset mid-mult aborts it
      cycle(1'b1, MDOP_MULT, 32'd6, 32'd7, 1'b0);
      idle(2, 1'b0);
      reset = 1'b0;
      #1;
      chk("t5_busy", {63'd0, busy}, 64'd0);
      peek("t5", 32'd0, 32'd0);
      m_hi = '0; m_lo = '0; m_left = 0; m_we = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      cycle(1'b1, MDOP_MULT, 32'd3, 32'd4, 1'b0);
      idle(MULT_N, 1'b0);
      peek("t5_after", 32'd0, 32'd12);

      // 6: maddu
      cycle(1'b1, MDOP_MTHI, 32'd0, 32'd0, 1'b0);
      cycle(1'b1, MDOP_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
      cycle(1'b1, MDOP_MADDU, 32'd1, 32'd1, 1'b1);
      idle(MULT_N, 1'b0);
`ifdef MDU_MADD_EN
      peek("t6", 32'd1, 32'd0);
`else
      peek("t6", 32'd0, 32'hFFFF_FFFF);
`endif

      // Random ops against the model
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a, b;
         a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
         cycle(1'($urandom_range(0, 1)), ops[$urandom_range(0, 12)], a, b, 1'($urandom_range(0, 1)));
      end
      idle(DIV_N, 1'b0);
      peek("rand_end", m_hi, m_lo);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
